// File: rtl/kix_filter_n.sv
// Pipelined direct-form FIR: delay line, registered products, then a binary adder
// tree with one register per level. Full-precision output, no rounding or saturation.
module kix_filter_n #(
    parameter  int width    = 16,
    parameter  int ncfwidth = 16,
    parameter  int length   = 15,
    localparam int NT       = length + 1,
    localparam int LOG2_NT  = $clog2(NT),
    localparam int OUTW     = ncfwidth + width + LOG2_NT
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ena,
    input  logic signed [width-1:0]  data_in,
    input  logic [NT*ncfwidth-1:0]   coeff_concat,
    output logic [NT*width-1:0]      delays,
    output logic signed [OUTW-1:0]   kix_out
);

    localparam int NL = 1 << LOG2_NT;
    localparam int PW = width + ncfwidth;

    logic signed [width-1:0]    r_xd    [0:NT-1];
    logic signed [ncfwidth-1:0] w_coeff [0:NT-1];
    logic signed [PW-1:0]       r_prod  [0:NT-1];
    // Heap-ordered tree: nodes 0..NL-2 are registered sums, NL-1..2*NL-2 are leaves.
    logic signed [OUTW-1:0]     w_tree  [0:2*NL-2];

    for (genvar g = 0; g < NT; g++) begin : g_tap
        assign w_coeff[g]                        = $signed(coeff_concat[(g+1)*ncfwidth-1 -: ncfwidth]);
        assign delays[(g+1)*width-1 -: width]    = r_xd[g];
    end

    for (genvar g = 0; g < NL; g++) begin : g_leaf
        if (g < NT) begin : g_used
            assign w_tree[NL-1+g] = OUTW'(r_prod[g]);
        end else begin : g_pad
            assign w_tree[NL-1+g] = '0;
        end
    end

    // NOTE: these arrays are pipeline registers, not a memory; clearing them on
    // reset is exactly what flushes the filter history.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NT; i++) begin
                r_xd[i]   <= '0;
                r_prod[i] <= '0;
            end
        end else if (ena) begin
            // NOTE: non-blocking updates make every tap see its neighbour's old
            // value, so the line shifts by exactly one position per edge.
            r_xd[0] <= data_in;
            for (int i = 1; i < NT; i++) begin
                r_xd[i] <= r_xd[i-1];
            end
            for (int i = 0; i < NT; i++) begin
                r_prod[i] <= PW'(r_xd[i]) * PW'(w_coeff[i]);
            end
        end
    end

    if (NL > 1) begin : g_tree
        logic signed [OUTW-1:0] r_node [0:NL-2];

        always_ff @(posedge clk) begin
            if (!resetn) begin
                for (int k = 0; k < NL-1; k++) begin
                    r_node[k] <= '0;
                end
            end else if (ena) begin
                for (int k = 0; k < NL-1; k++) begin
                    r_node[k] <= w_tree[2*k+1] + w_tree[2*k+2];
                end
            end
        end

        for (genvar k = 0; k < NL-1; k++) begin : g_node
            assign w_tree[k] = r_node[k];
        end
    end

    assign kix_out = w_tree[0];

endmodule

// File: tb/tb_kix_filter_n.sv
// Self-checking bench for kix_filter_n: table-driven impulse, directed corner
// sequences, and long random streams against a sample-history convolution model.
module tb_kix_filter_n;

    localparam int W    = 16;
    localparam int CW   = 16;
    localparam int LEN  = 15;
    localparam int NT   = LEN + 1;
    localparam int L2   = 4;
    localparam int OUTW = CW + W + L2;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   ena;
    logic signed [W-1:0]    data_in;
    logic [NT*CW-1:0]       coeff_concat;
    logic [NT*W-1:0]        delays;
    logic signed [OUTW-1:0] kix_out;

    kix_filter_n #(.width(W), .ncfwidth(CW), .length(LEN)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ena          (ena),
        .data_in      (data_in),
        .coeff_concat (coeff_concat),
        .delays       (delays),
        .kix_out      (kix_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] din;
        longint              y;
    } vec_t;

    int       c [NT];
    longint   xs[$];
    longint   exp_q[$];
    longint   exp_y;
    logic [NT*W-1:0] exp_d;
    int       checks = 0;
    int       errors = 0;
    vec_t     tbl [24];
    longint   frozen;

    task automatic check(input string name, input logic signed [NT*W-1:0] act,
                         input logic signed [NT*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_coeffs();
        for (int i = 0; i < NT; i++) coeff_concat[(i+1)*CW-1 -: CW] = CW'(c[i]);
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Model: y after enabled edge m = sum_i c_i(edge m-L2) * x[m-1-L2-i].
    task automatic model_reset();
        xs.delete();
        exp_q.delete();
        for (int i = 0; i < L2; i++) exp_q.push_back(0);
        exp_y = 0;
        exp_d = '0;
    endtask

    task automatic model_edge(input longint din);
        longint acc = 0;
        for (int i = 0; i < NT; i++)
            if (xs.size() > i) acc += longint'(c[i]) * xs[xs.size()-1-i];
        exp_q.push_back(acc);
        exp_y = exp_q.pop_front();
        xs.push_back(din);
        if (xs.size() > NT) void'(xs.pop_front());
        for (int i = 0; i < NT; i++)
            exp_d[(i+1)*W-1 -: W] = (xs.size() > i) ? W'(xs[xs.size()-1-i]) : '0;
    endtask

    task automatic tick();
        logic   r = resetn;
        logic   e = ena;
        longint d = data_in;
        @(posedge clk);
        if (!r) model_reset();
        else if (e) model_edge(d);
        #1;
        check("kix_out", kix_out, exp_y);
        check("delays", delays, exp_d);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        for (int i = 0; i < n; i++) tick();
        check("reset_out", kix_out, 0);
        check("reset_delays", delays, 0);
        resetn = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < 24; r++) begin
            tbl[r].din = (r == 0) ? 16'sd1 : 16'sd0;
            tbl[r].y   = (r >= 5 && r <= 20) ? longint'(r - 4) : 0;
        end

        resetn = 1'b0; ena = 1'b1; data_in = '0; coeff_concat = '0;
        for (int i = 0; i < NT; i++) c[i] = 0;
        model_reset();
        do_reset(2);

        // Impulse response with c_i = i+1
        for (int i = 0; i < NT; i++) c[i] = i + 1;
        set_coeffs();
        for (int r = 0; r < 24; r++) begin
            data_in = tbl[r].din;
            tick();
            check("impulse", kix_out, tbl[r].y);
        end

        // Extremes: most negative sample and coefficient everywhere
        do_reset(1);
        for (int i = 0; i < NT; i++) c[i] = -32768;
        set_coeffs();
        data_in = -16'sd32768;
        for (int m = 0; m < 25; m++) tick();
        check("extreme", kix_out, 64'sd1 <<< 34);

        // Step: ramp 300..4800 and hold
        do_reset(1);
        for (int i = 0; i < NT; i++) c[i] = 3;
        set_coeffs();
        data_in = 16'sd100;
        for (int m = 1; m <= 25; m++) begin
            tick();
            check("ramp", kix_out, (m >= 6) ? longint'(300 * ((m - 5 > 16) ? 16 : m - 5)) : 0);
            if (m == 3) begin
                check("step_tap0", delays[W-1:0], 100);
                check("step_tap2", delays[3*W-1 -: W], 100);
                check("step_tap3", delays[4*W-1 -: W], 0);
            end
        end

        // Enable freeze mid-stream
        for (int i = 0; i < NT; i++) c[i] = rnd16();
        set_coeffs();
        for (int m = 0; m < 12; m++) begin data_in = W'(rnd16()); tick(); end
        frozen = exp_y;
        ena = 1'b0;
        for (int m = 0; m < 5; m++) begin
            data_in = W'(rnd16());
            tick();
            check("freeze", kix_out, frozen);
        end
        ena = 1'b1;
        for (int m = 0; m < 20; m++) begin data_in = W'(rnd16()); tick(); end

        // Reset mid-run flushes history
        for (int m = 0; m < 20; m++) begin data_in = W'(rnd16()); tick(); end
        do_reset(2);
        for (int m = 0; m < 30; m++) begin data_in = W'(rnd16()); tick(); end

        // Long random stream, coefficients reloaded periodically
        for (int m = 0; m < 10000; m++) begin
            if (m % 500 == 0) begin
                for (int i = 0; i < NT; i++) c[i] = rnd16();
                set_coeffs();
            end
            data_in = ($urandom_range(0, 15) == 0) ? -16'sd32768 : W'(rnd16());
            tick();
        end

        // Random enable, coefficient changes and occasional reset
        for (int m = 0; m < 1500; m++) begin
            ena    = ($urandom_range(0, 3) != 0);
            resetn = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 49) == 0) begin
                c[$urandom_range(0, NT-1)] = rnd16();
                set_coeffs();
            end
            data_in = W'(rnd16());
            tick();
        end
        resetn = 1'b1;
        ena    = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
